// File: rtl/render_frame_sequencer.sv
`default_nettype none
// ============================================================================
// render_frame_sequencer
// Vblank snapshot of player state, damage-flash timers and game-over sequencing.
// Revision: 1.0
// ============================================================================
module render_frame_sequencer #(
  parameter int H_TOTAL      = 800,
  parameter int LATCH_LINE   = 515,
  parameter int FLASH_FRAMES = 8,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  input  logic [9:0] p1_x,
  input  logic [9:0] p1_y,
  input  logic [9:0] p2_x,
  input  logic [9:0] p2_y,
  input  logic [3:0] p1_health,
  input  logic [3:0] p2_health,
  input  logic [3:0] p1_shield,
  input  logic [3:0] p2_shield,
  input  logic [6:0] p1_action,
  input  logic [6:0] p2_action,
  input  logic [1:0] finish_req,
  output logic       frame_tick,
  output logic [9:0] p1_x_r,
  output logic [9:0] p1_y_r,
  output logic [9:0] p2_x_r,
  output logic [9:0] p2_y_r,
  output logic [3:0] p1_health_r,
  output logic [3:0] p2_health_r,
  output logic [3:0] p1_shield_r,
  output logic [3:0] p2_shield_r,
  output logic [6:0] p1_action_r,
  output logic [6:0] p2_action_r,
  output logic       p1_flash,
  output logic       p2_flash,
  output logic [1:0] finish,
  output logic       banner_on,
  output logic [15:0] frame_count
);

  localparam logic [9:0] C_H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] C_LATCH_LINE = 10'(LATCH_LINE);
  localparam logic [3:0] C_FLASH_LOAD = 4'(FLASH_FRAMES);
  localparam logic [5:0] C_BLINK_LAST = 6'(BLINK_FRAMES - 1);

  typedef enum logic [0:0] {
    PLAY = 1'b0,
    OVER = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        w_snap;
  logic        w_flash_load_ok;

  logic        frame_tick_q, frame_tick_d;
  logic [9:0]  p1_x_q, p1_x_d, p1_y_q, p1_y_d, p2_x_q, p2_x_d, p2_y_q, p2_y_d;
  logic [3:0]  p1_health_q, p1_health_d, p2_health_q, p2_health_d;
  logic [3:0]  p1_shield_q, p1_shield_d, p2_shield_q, p2_shield_d;
  logic [6:0]  p1_action_q, p1_action_d, p2_action_q, p2_action_d;
  logic [3:0]  p1_fc_q, p1_fc_d, p2_fc_q, p2_fc_d;
  logic        p1_flash_q, p1_flash_d, p2_flash_q, p2_flash_d;
  logic [1:0]  finish_q, finish_d;
  logic        banner_q, banner_d;
  logic [5:0]  blink_q, blink_d;
  logic [15:0] frame_count_q, frame_count_d;

  function automatic logic [3:0] fc_next(input logic load, input logic [3:0] fc);
    if (load)
      return C_FLASH_LOAD;
    else if (fc != 4'd0)
      return fc - 4'd1;
    else
      return 4'd0;
  endfunction

  assign w_snap = (hCount == C_H_LAST) && (vCount == C_LATCH_LINE);

  // Flash counters only arm while play continues through this snapshot.
  assign w_flash_load_ok = (state_q == PLAY) && !finish_req[1];

  always_comb begin
    state_d       = state_q;
    frame_tick_d  = 1'b0;
    p1_x_d        = p1_x_q;
    p1_y_d        = p1_y_q;
    p2_x_d        = p2_x_q;
    p2_y_d        = p2_y_q;
    p1_health_d   = p1_health_q;
    p2_health_d   = p2_health_q;
    p1_shield_d   = p1_shield_q;
    p2_shield_d   = p2_shield_q;
    p1_action_d   = p1_action_q;
    p2_action_d   = p2_action_q;
    p1_fc_d       = p1_fc_q;
    p2_fc_d       = p2_fc_q;
    finish_d      = finish_q;
    banner_d      = banner_q;
    blink_d       = blink_q;
    frame_count_d = frame_count_q;

    if (w_snap) begin
      frame_tick_d  = 1'b1;
      frame_count_d = frame_count_q + 16'd1;
      p1_x_d        = p1_x;
      p1_y_d        = p1_y;
      p2_x_d        = p2_x;
      p2_y_d        = p2_y;
      p1_health_d   = p1_health;
      p2_health_d   = p2_health;
      p1_shield_d   = p1_shield;
      p2_shield_d   = p2_shield;
      p1_action_d   = p1_action;
      p2_action_d   = p2_action;
      p1_fc_d       = fc_next(w_flash_load_ok && (p1_health < p1_health_q), p1_fc_q);
      p2_fc_d       = fc_next(w_flash_load_ok && (p2_health < p2_health_q), p2_fc_q);

      case (state_q)
        PLAY: begin
          if (finish_req[1]) begin
            state_d  = OVER;
            finish_d = {1'b1, finish_req[0]};
            banner_d = 1'b1;
            blink_d  = 6'd0;
          end
        end
        OVER: begin
          if (!finish_req[1]) begin
            state_d  = PLAY;
            finish_d = 2'b00;
            banner_d = 1'b0;
            blink_d  = 6'd0;
            p1_fc_d  = 4'd0;
            p2_fc_d  = 4'd0;
          end else if (blink_q == C_BLINK_LAST) begin
            blink_d  = 6'd0;
            banner_d = !banner_q;
          end else begin
            blink_d  = blink_q + 6'd1;
          end
        end
        default: state_d = PLAY;
      endcase
    end

    p1_flash_d = (p1_fc_d != 4'd0);
    p2_flash_d = (p2_fc_d != 4'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= PLAY;
      frame_tick_q  <= 1'b0;
      p1_x_q        <= 10'd0;
      p1_y_q        <= 10'd0;
      p2_x_q        <= 10'd0;
      p2_y_q        <= 10'd0;
      // Full health at reset so the first snapshot never reads as a drop.
      p1_health_q   <= 4'hF;
      p2_health_q   <= 4'hF;
      p1_shield_q   <= 4'd0;
      p2_shield_q   <= 4'd0;
      p1_action_q   <= 7'd0;
      p2_action_q   <= 7'd0;
      p1_fc_q       <= 4'd0;
      p2_fc_q       <= 4'd0;
      p1_flash_q    <= 1'b0;
      p2_flash_q    <= 1'b0;
      finish_q      <= 2'b00;
      banner_q      <= 1'b0;
      blink_q       <= 6'd0;
      frame_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      frame_tick_q  <= frame_tick_d;
      p1_x_q        <= p1_x_d;
      p1_y_q        <= p1_y_d;
      p2_x_q        <= p2_x_d;
      p2_y_q        <= p2_y_d;
      p1_health_q   <= p1_health_d;
      p2_health_q   <= p2_health_d;
      p1_shield_q   <= p1_shield_d;
      p2_shield_q   <= p2_shield_d;
      p1_action_q   <= p1_action_d;
      p2_action_q   <= p2_action_d;
      p1_fc_q       <= p1_fc_d;
      p2_fc_q       <= p2_fc_d;
      p1_flash_q    <= p1_flash_d;
      p2_flash_q    <= p2_flash_d;
      finish_q      <= finish_d;
      banner_q      <= banner_d;
      blink_q       <= blink_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_tick  = frame_tick_q;
  assign p1_x_r      = p1_x_q;
  assign p1_y_r      = p1_y_q;
  assign p2_x_r      = p2_x_q;
  assign p2_y_r      = p2_y_q;
  assign p1_health_r = p1_health_q;
  assign p2_health_r = p2_health_q;
  assign p1_shield_r = p1_shield_q;
  assign p2_shield_r = p2_shield_q;
  assign p1_action_r = p1_action_q;
  assign p2_action_r = p2_action_q;
  assign p1_flash    = p1_flash_q;
  assign p2_flash    = p2_flash_q;
  assign finish      = finish_q;
  assign banner_on   = banner_q;
  assign frame_count = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_render_frame_sequencer.sv
`default_nettype none
// ============================================================================
// tb_render_frame_sequencer
// Scoreboard bench: expected snapshots queued at each latch point, popped on frame_tick.
// Revision: 1.0
// ============================================================================
module tb_render_frame_sequencer;

  localparam int H_TOTAL      = 800;
  localparam int LATCH_LINE   = 515;
  localparam int FLASH_FRAMES = 8;
  localparam int BLINK_FRAMES = 30;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  hCount = 10'd0, vCount = 10'd0;
  logic [9:0]  p1_x = 10'd0, p1_y = 10'd0, p2_x = 10'd0, p2_y = 10'd0;
  logic [3:0]  p1_health = 4'hF, p2_health = 4'hF, p1_shield = 4'd0, p2_shield = 4'd0;
  logic [6:0]  p1_action = 7'd0, p2_action = 7'd0;
  logic [1:0]  finish_req = 2'b00;
  logic        frame_tick;
  logic [9:0]  p1_x_r, p1_y_r, p2_x_r, p2_y_r;
  logic [3:0]  p1_health_r, p2_health_r, p1_shield_r, p2_shield_r;
  logic [6:0]  p1_action_r, p2_action_r;
  logic        p1_flash, p2_flash;
  logic [1:0]  finish;
  logic        banner_on;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  render_frame_sequencer #(
    .H_TOTAL(H_TOTAL), .LATCH_LINE(LATCH_LINE),
    .FLASH_FRAMES(FLASH_FRAMES), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk), .rst(rst), .hCount(hCount), .vCount(vCount),
    .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .p1_health(p1_health), .p2_health(p2_health),
    .p1_shield(p1_shield), .p2_shield(p2_shield),
    .p1_action(p1_action), .p2_action(p2_action),
    .finish_req(finish_req), .frame_tick(frame_tick),
    .p1_x_r(p1_x_r), .p1_y_r(p1_y_r), .p2_x_r(p2_x_r), .p2_y_r(p2_y_r),
    .p1_health_r(p1_health_r), .p2_health_r(p2_health_r),
    .p1_shield_r(p1_shield_r), .p2_shield_r(p2_shield_r),
    .p1_action_r(p1_action_r), .p2_action_r(p2_action_r),
    .p1_flash(p1_flash), .p2_flash(p2_flash), .finish(finish),
    .banner_on(banner_on), .frame_count(frame_count)
  );

  typedef logic [90:0] snap_t;

  int     checks = 0;
  int     errors = 0;
  int     tick_count = 0;
  snap_t  exp_q[$];
  snap_t  mon_exp;
  snap_t  dut_vec;

  // Reference model state
  logic [3:0]  m_h1, m_h2, m_fc1, m_fc2;
  logic        m_over, m_win, m_banner;
  int          m_blink;
  logic [15:0] m_cnt;

  assign dut_vec = {p1_x_r, p1_y_r, p2_x_r, p2_y_r, p1_health_r, p2_health_r,
                    p1_shield_r, p2_shield_r, p1_action_r, p2_action_r,
                    p1_flash, p2_flash, finish, banner_on, frame_count};

  always @(negedge clk) begin
    if (frame_tick) begin
      tick_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL frame_tick_spurious: got pulse at t=%0t, expected none", $time);
      end else begin
        mon_exp = exp_q.pop_front();
        if (dut_vec !== mon_exp) begin
          errors++;
          $display("FAIL snapshot: got %h expected %h", dut_vec, mon_exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_h1 = 4'hF; m_h2 = 4'hF; m_fc1 = 4'd0; m_fc2 = 4'd0;
    m_over = 1'b0; m_win = 1'b0; m_banner = 1'b0; m_blink = 0; m_cnt = 16'd0;
    exp_q.delete();
  endtask

  // One compressed frame: near-miss positions, then the latch point, then line start.
  task automatic frame();
    hCount = 10'(H_TOTAL - 1); vCount = 10'(LATCH_LINE - 1); step();
    hCount = 10'(H_TOTAL - 2); vCount = 10'(LATCH_LINE);     step();
    p1_y = 10'($urandom); p2_y = 10'($urandom);
    p1_shield = 4'($urandom); p2_shield = 4'($urandom);
    p1_action = 7'($urandom); p2_action = 7'($urandom);
    hCount = 10'(H_TOTAL - 1); vCount = 10'(LATCH_LINE);
    m_cnt = m_cnt + 16'd1;
    if (m_over) begin
      m_fc1 = (m_fc1 != 0) ? m_fc1 - 4'd1 : 4'd0;
      m_fc2 = (m_fc2 != 0) ? m_fc2 - 4'd1 : 4'd0;
      if (!finish_req[1]) begin
        m_over = 1'b0; m_banner = 1'b0; m_fc1 = 4'd0; m_fc2 = 4'd0;
      end else if (m_blink == BLINK_FRAMES - 1) begin
        m_blink = 0; m_banner = ~m_banner;
      end else begin
        m_blink++;
      end
    end else if (finish_req[1]) begin
      m_over = 1'b1; m_win = finish_req[0]; m_banner = 1'b1; m_blink = 0;
      m_fc1 = (m_fc1 != 0) ? m_fc1 - 4'd1 : 4'd0;
      m_fc2 = (m_fc2 != 0) ? m_fc2 - 4'd1 : 4'd0;
    end else begin
      if (p1_health < m_h1) m_fc1 = 4'(FLASH_FRAMES);
      else if (m_fc1 != 0) m_fc1 = m_fc1 - 4'd1;
      if (p2_health < m_h2) m_fc2 = 4'(FLASH_FRAMES);
      else if (m_fc2 != 0) m_fc2 = m_fc2 - 4'd1;
    end
    m_h1 = p1_health; m_h2 = p2_health;
    exp_q.push_back({p1_x, p1_y, p2_x, p2_y, p1_health, p2_health, p1_shield, p2_shield,
                     p1_action, p2_action, (m_fc1 != 0), (m_fc2 != 0),
                     m_over, m_over & m_win, m_banner, m_cnt});
    step();
    hCount = 10'd0; vCount = 10'(LATCH_LINE + 1); step();
  endtask

  task automatic test_reset();
    p1_x = 10'd200; p2_x = 10'd500;
    rst = 1'b1; step(); step();
    rst = 1'b0; model_reset();
    checks++; if (p1_x_r !== 10'd0) begin errors++; $display("FAIL reset_p1_x: got %0d expected 0", p1_x_r); end
    checks++; if (p2_x_r !== 10'd0) begin errors++; $display("FAIL reset_p2_x: got %0d expected 0", p2_x_r); end
    checks++; if (p1_health_r !== 4'hF || p2_health_r !== 4'hF) begin errors++; $display("FAIL reset_health: got %h/%h expected F/F", p1_health_r, p2_health_r); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_frame_count: got %0d expected 0", frame_count); end
    checks++; if (finish !== 2'b00 || banner_on !== 1'b0) begin errors++; $display("FAIL reset_over: got finish=%b banner=%b expected 00/0", finish, banner_on); end
    checks++; if (p1_flash !== 1'b0 || p2_flash !== 1'b0 || frame_tick !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b%b%b expected 000", p1_flash, p2_flash, frame_tick); end
  endtask

  task automatic test_snapshot();
    int t0;
    hCount = 10'd5; vCount = 10'(LATCH_LINE); step();
    hCount = 10'(H_TOTAL - 1); vCount = 10'd0; step();
    checks++; if (p1_x_r !== 10'd0) begin errors++; $display("FAIL pre_snapshot_hold: got %0d expected 0", p1_x_r); end
    t0 = tick_count;
    repeat (3) frame();
    checks++; if (tick_count - t0 !== 3) begin errors++; $display("FAIL tick_count: got %0d expected 3", tick_count - t0); end
    checks++; if (frame_count !== 16'd3) begin errors++; $display("FAIL frame_count: got %0d expected 3", frame_count); end
    checks++; if (p1_x_r !== 10'd200 || p2_x_r !== 10'd500) begin errors++; $display("FAIL snap_x: got %0d/%0d expected 200/500", p1_x_r, p2_x_r); end
  endtask

  task automatic test_mid_frame();
    hCount = 10'd50; vCount = 10'd100; p1_x = 10'd300;
    repeat (4) step();
    checks++; if (p1_x_r !== 10'd200) begin errors++; $display("FAIL mid_frame_hold: got %0d expected 200", p1_x_r); end
    frame();
    checks++; if (p1_x_r !== 10'd300) begin errors++; $display("FAIL mid_frame_load: got %0d expected 300", p1_x_r); end
  endtask

  task automatic test_flash();
    int n;
    p1_health = 4'd13; n = 0;
    for (int i = 0; i < 10; i++) begin
      frame();
      if (p1_flash) n++;
    end
    checks++; if (n !== FLASH_FRAMES) begin errors++; $display("FAIL p1_flash_len: got %0d expected %0d", n, FLASH_FRAMES); end
    p2_health = 4'd12; n = 0;
    for (int i = 1; i <= 14; i++) begin
      if (i == 5) p2_health = 4'd10;
      frame();
      if (p2_flash) n++;
    end
    checks++; if (n !== 12) begin errors++; $display("FAIL p2_flash_reload: got %0d expected 12", n); end
    checks++; if (p2_flash !== 1'b0) begin errors++; $display("FAIL p2_flash_end: got %b expected 0", p2_flash); end
    p2_health = 4'hF; frame();
    checks++; if (p2_flash !== 1'b0) begin errors++; $display("FAIL p2_flash_raise: got %b expected 0", p2_flash); end
  endtask

  task automatic test_game_over();
    logic exp_b;
    finish_req = 2'b11; frame();
    checks++; if (finish !== 2'b11 || banner_on !== 1'b1) begin errors++; $display("FAIL over_entry: got finish=%b banner=%b expected 11/1", finish, banner_on); end
    finish_req = 2'b10;
    for (int k = 1; k <= 60; k++) begin
      frame();
      exp_b = ((k / BLINK_FRAMES) % 2) == 0;
      checks++; if (banner_on !== exp_b || finish !== 2'b11) begin errors++; $display("FAIL blink_k%0d: got banner=%b finish=%b expected %b/11", k, banner_on, finish, exp_b); end
    end
  endtask

  task automatic test_resume();
    finish_req = 2'b00; frame();
    checks++; if (finish !== 2'b00 || banner_on !== 1'b0) begin errors++; $display("FAIL resume: got finish=%b banner=%b expected 00/0", finish, banner_on); end
    p2_health = 4'd9; frame();
    checks++; if (p2_flash !== 1'b1) begin errors++; $display("FAIL resume_flash: got %b expected 1", p2_flash); end
    finish_req = 2'b11; p1_health = 4'd5; frame();
    checks++; if (p1_flash !== 1'b0 || p2_flash !== 1'b1 || finish !== 2'b11) begin errors++; $display("FAIL drop_on_over: got p1=%b p2=%b finish=%b expected 0/1/11", p1_flash, p2_flash, finish); end
    frame();
    finish_req = 2'b00; frame();
    checks++; if (p1_flash !== 1'b0 || p2_flash !== 1'b0 || finish !== 2'b00) begin errors++; $display("FAIL exit_clears_flash: got p1=%b p2=%b finish=%b expected 0/0/00", p1_flash, p2_flash, finish); end
  endtask

  task automatic test_reset_in_over();
    p1_health = 4'd2; frame();
    finish_req = 2'b11; frame();
    checks++; if (p1_flash !== 1'b1 || finish !== 2'b11) begin errors++; $display("FAIL pre_reset_state: got p1=%b finish=%b expected 1/11", p1_flash, finish); end
    hCount = 10'd10; vCount = 10'd100; rst = 1'b1; step();
    rst = 1'b0; model_reset();
    checks++; if (p1_flash !== 1'b0 || finish !== 2'b00 || banner_on !== 1'b0) begin errors++; $display("FAIL mid_reset: got p1=%b finish=%b banner=%b expected 0/00/0", p1_flash, finish, banner_on); end
    checks++; if (frame_count !== 16'd0 || p1_x_r !== 10'd0 || p1_health_r !== 4'hF) begin errors++; $display("FAIL mid_reset_regs: got cnt=%0d x=%0d h=%h expected 0/0/F", frame_count, p1_x_r, p1_health_r); end
    hCount = 10'(H_TOTAL - 1); vCount = 10'(LATCH_LINE); rst = 1'b1; step();
    rst = 1'b0; hCount = 10'd0; vCount = 10'(LATCH_LINE + 1);
    checks++; if (frame_tick !== 1'b0 || frame_count !== 16'd0 || p1_x_r !== 10'd0) begin errors++; $display("FAIL reset_beats_snap: got tick=%b cnt=%0d x=%0d expected 0/0/0", frame_tick, frame_count, p1_x_r); end
    finish_req = 2'b00; p1_health = 4'd14; frame();
    checks++; if (p1_flash !== 1'b1 || frame_count !== 16'd1) begin errors++; $display("FAIL post_reset_drop: got p1=%b cnt=%0d expected 1/1", p1_flash, frame_count); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_snapshot();
    test_mid_frame();
    test_flash();
    test_game_over();
    test_resume();
    test_reset_in_over();
    repeat (4) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
